sha1_padder: RTL and testbench

Upstream message-preparation stage for the SHA-1 APB core. It accepts an arbitrary-length byte stream, packs bytes big-endian into 32-bit words, and appends FIPS 180-4 padding: a `0x80` byte, zero fill, and the 64-bit message bit length. It emits a word stream of complete 16-word blocks, which the feeding logic writes into the core's message registers (addresses 0–15), one block per hash run.

---
 rtl/sha1_pkg.sv | 17 +
 rtl/sha1_padder_if.sv | 28 ++
 rtl/sha1_byte_packer.sv | 66 ++++++
 rtl/sha1_padder.sv | 162 ++++++++++++++++
 tb/tb_sha1_padder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } sha1_pad_state_t;

  localparam int unsigned SHA1_BLOCK_WORDS = 16;
  localparam int unsigned SHA1_IDX_W       = $clog2(SHA1_BLOCK_WORDS);
  localparam int unsigned SHA1_LEN_HI_IDX  = 14;
  localparam logic [7:0]  SHA1_PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-in / word-out handshake bundle of the SHA-1 message padder.
interface sha1_padder_if;
  import sha1_pkg::*;

  logic                  DIN_VALID_IN;
  logic [7:0]            DIN_DATA_IN;
  logic                  DIN_LAST_IN;
  logic                  DIN_EMPTY_IN;
  logic                  DIN_READY_OUT;
  logic                  WORD_VALID_OUT;
  logic [31:0]           WORD_DATA_OUT;
  logic [SHA1_IDX_W-1:0] WORD_IDX_OUT;
  logic                  MSG_LAST_OUT;
  logic                  WORD_READY_IN;

  // Padder side.
  modport slave (
    input  DIN_VALID_IN, DIN_DATA_IN, DIN_LAST_IN, DIN_EMPTY_IN, WORD_READY_IN,
    output DIN_READY_OUT, WORD_VALID_OUT, WORD_DATA_OUT, WORD_IDX_OUT, MSG_LAST_OUT
  );

  // Byte source / word sink side.
  modport master (
    output DIN_VALID_IN, DIN_DATA_IN, DIN_LAST_IN, DIN_EMPTY_IN, WORD_READY_IN,
    input  DIN_READY_OUT, WORD_VALID_OUT, WORD_DATA_OUT, WORD_IDX_OUT, MSG_LAST_OUT
  );

endinterface

// File: rtl/sha1_byte_packer.sv
// Holds up to three pending message bytes (newest in [7:0]) and forms
// full data words and 0x80-terminated pad words from them.
module sha1_byte_packer
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [1:0]  pend_cnt,
  output logic [31:0] full_word,
  output logic [31:0] pad_with_byte,
  output logic [31:0] pad_pending
);

  logic [23:0] held_q, held_d;
  logic [1:0]  cnt_q,  cnt_d;

  // Left-justify n bytes of a right-aligned buffer, then 0x80, then zeros.
  function automatic logic [31:0] form_pad(input logic [23:0] bytes, input logic [1:0] n);
    case (n)
      2'd0:    form_pad = {SHA1_PAD_BYTE, 24'h0};
      2'd1:    form_pad = {bytes[7:0], SHA1_PAD_BYTE, 16'h0};
      2'd2:    form_pad = {bytes[15:0], SHA1_PAD_BYTE, 8'h0};
      default: form_pad = {bytes[23:0], SHA1_PAD_BYTE};
    endcase
  endfunction

  assign pend_cnt      = cnt_q;
  assign full_word     = {held_q, byte_in};
  assign pad_with_byte = form_pad({held_q[15:0], byte_in}, cnt_q + 2'd1);
  assign pad_pending   = form_pad(held_q, cnt_q);

  // Next packer contents: clear wins, a 4th byte empties the buffer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    held_d = held_q;
    cnt_d  = cnt_q;
    if (clear) begin
      held_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      if (cnt_q == 2'd3) begin
        held_d = '0;
        cnt_d  = '0;
      end else begin
        held_d = {held_q[15:0], byte_in};
        cnt_d  = cnt_q + 2'd1;
      end
    end
  end

  // Packer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      held_q <= '0;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into big-endian words and
// appends 0x80, zero fill and the 64-bit bit length as 16-word blocks.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input  logic          PCLK_IN,
  input  logic          PRESETn_IN,
  sha1_padder_if.slave  bus
);

  localparam logic [SHA1_IDX_W-1:0] LEN_HI_IDX = SHA1_IDX_W'(SHA1_LEN_HI_IDX);

  sha1_pad_state_t       state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [SHA1_IDX_W-1:0] word_idx_q, word_idx_d;   // index the next loaded word gets
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_data_q, out_data_d;
  logic [SHA1_IDX_W-1:0] out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;

  logic        can_load, din_ready, din_fire, next_is_len;
  logic        load_en, load_last, pk_shift, pk_clear;
  logic [31:0] load_word;
  logic [63:0] msg_len;
  logic [1:0]  pend_cnt;
  logic [31:0] full_word, pad_with_byte, pad_pending;

  sha1_byte_packer u_packer (
    .clk           (PCLK_IN),
    .rst_n         (PRESETn_IN),
    .shift_en      (pk_shift),
    .clear         (pk_clear),
    .byte_in       (bus.DIN_DATA_IN),
    .pend_cnt      (pend_cnt),
    .full_word     (full_word),
    .pad_with_byte (pad_with_byte),
    .pad_pending   (pad_pending)
  );

  assign can_load    = !out_valid_q || bus.WORD_READY_IN;
  assign din_ready   = PRESETn_IN && (state_q == S_DATA) && can_load;
  assign din_fire    = bus.DIN_VALID_IN && din_ready;
  assign next_is_len = (word_idx_q + 1'b1) == LEN_HI_IDX;
  assign msg_len     = 64'(byte_cnt_q) << 3;

  // FSM next state, word selection and packer control.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    load_en    = 1'b0;
    load_word  = '0;
    load_last  = 1'b0;
    pk_shift   = 1'b0;
    pk_clear   = 1'b0;
    case (state_q)
      S_DATA: begin
        if (din_fire) begin
          if (bus.DIN_EMPTY_IN) begin
            // An empty beat only matters when it terminates the message.
            if (bus.DIN_LAST_IN) state_d = S_PAD;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            pk_shift   = 1'b1;
            if (pend_cnt == 2'd3) begin
              load_en   = 1'b1;
              load_word = full_word;
              if (bus.DIN_LAST_IN) state_d = S_PAD;
            end else if (bus.DIN_LAST_IN) begin
              load_en   = 1'b1;
              load_word = pad_with_byte;
              pk_clear  = 1'b1;
              state_d   = next_is_len ? S_LEN_HI : S_ZERO;
            end
          end
        end
      end
      S_PAD: begin
        if (can_load) begin
          load_en   = 1'b1;
          load_word = pad_pending;
          pk_clear  = 1'b1;
          state_d   = next_is_len ? S_LEN_HI : S_ZERO;
        end
      end
      S_ZERO: begin
        if (can_load) begin
          load_en = 1'b1;
          if (next_is_len) state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (can_load) begin
          load_en   = 1'b1;
          load_word = msg_len[63:32];
          state_d   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (can_load) begin
          load_en    = 1'b1;
          load_word  = msg_len[31:0];
          load_last  = 1'b1;
          byte_cnt_d = '0;
          pk_clear   = 1'b1;
          state_d    = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  // Output register: drop on handshake, reload when a new word is chosen.
  // The index after word 15 wraps to 0, which also resets it for the next message.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    word_idx_d  = word_idx_q;
    if (out_valid_q && bus.WORD_READY_IN) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = load_word;
      out_idx_d   = word_idx_q;
      out_last_d  = load_last;
      word_idx_d  = word_idx_q + 1'b1;
    end
  end

  // State, counters and output register.
  always_ff @(posedge PCLK_IN or negedge PRESETn_IN) begin
    if (!PRESETn_IN) begin
      state_q     <= S_DATA;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.DIN_READY_OUT  = din_ready;
  assign bus.WORD_VALID_OUT = out_valid_q;
  assign bus.WORD_DATA_OUT  = out_data_q;
  assign bus.WORD_IDX_OUT   = out_idx_q;
  assign bus.MSG_LAST_OUT   = out_last_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: known messages against hand-computed blocks.
module tb_sha1_padder;
  import sha1_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sha1_padder_if bus ();

  sha1_padder #(.CNT_W(61)) dut (
    .PCLK_IN    (clk),
    .PRESETn_IN (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] got_data[$];
  logic [3:0]  got_idx[$];
  logic        got_last[$];
  logic [31:0] exp_q[$];
  logic [7:0]  msg_q[$];
  bit          seen_last = 1'b0;

  // Record every completed output handshake (ready is stable from negedge to posedge).
  always @(negedge clk) begin
    if (rst_n && bus.WORD_VALID_OUT && bus.WORD_READY_IN) begin
      got_data.push_back(bus.WORD_DATA_OUT);
      got_idx.push_back(bus.WORD_IDX_OUT);
      got_last.push_back(bus.MSG_LAST_OUT);
      if (bus.MSG_LAST_OUT) seen_last = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_run();
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    exp_q.delete();
    msg_q.delete();
    seen_last = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  task automatic push_msg(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) msg_q.push_back(b);
  endtask

  // Present one input beat and hold it until accepted.
  task automatic send_beat(input logic [7:0] d, input bit last, input bit empty);
    int guard = 0;
    bus.DIN_VALID_IN = 1'b1;
    bus.DIN_DATA_IN  = d;
    bus.DIN_LAST_IN  = last;
    bus.DIN_EMPTY_IN = empty;
    @(negedge clk);
    while (!bus.DIN_READY_OUT && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("din_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.DIN_VALID_IN = 1'b0;
    bus.DIN_LAST_IN  = 1'b0;
    bus.DIN_EMPTY_IN = 1'b0;
  endtask

  // Send msg_q; terminate with LAST on the final byte, or an empty LAST beat if msg_q is empty.
  task automatic send_msg(input bit term);
    if (msg_q.size() == 0) begin
      if (term) send_beat(8'h00, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < msg_q.size(); i++)
        send_beat(msg_q[i], term && (i == msg_q.size() - 1), 1'b0);
    end
  endtask

  task automatic wait_last(input string name);
    int c = 0;
    while (!seen_last && c < 600) begin
      @(posedge clk);
      c++;
    end
    check({name, "_done"}, 64'(seen_last), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_run(input string name);
    check({name, "_count"}, 64'(got_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_w%0d_data", name, i), 64'(got_data[i]), 64'(exp_q[i]));
      check($sformatf("%s_w%0d_idx", name, i), 64'(got_idx[i]), 64'(i % 16));
      check($sformatf("%s_w%0d_last", name, i), 64'(got_last[i]), 64'(i == exp_q.size() - 1));
    end
  endtask

  task automatic expect_abc();
    exp_q.delete();
    push_exp(32'h61626380, 1);
    push_exp(32'h00000000, 14);
    push_exp(32'h00000018, 1);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.DIN_VALID_IN  = 1'b0;
    bus.DIN_DATA_IN   = 8'h00;
    bus.DIN_LAST_IN   = 1'b0;
    bus.DIN_EMPTY_IN  = 1'b0;
    bus.WORD_READY_IN = 1'b1;

    // Reset state.
    #13;
    check("rst_valid", 64'(bus.WORD_VALID_OUT), 0);
    check("rst_data", 64'(bus.WORD_DATA_OUT), 0);
    check("rst_idx", 64'(bus.WORD_IDX_OUT), 0);
    check("rst_last", 64'(bus.MSG_LAST_OUT), 0);
    check("rst_din_ready", 64'(bus.DIN_READY_OUT), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_din_ready", 64'(bus.DIN_READY_OUT), 1);
    @(posedge clk);
    #1;

    // "abc".
    clear_run();
    load_abc();
    send_msg(1'b1);
    wait_last("abc");
    expect_abc();
    compare_run("abc");

    // Empty message.
    clear_run();
    send_msg(1'b1);
    wait_last("empty");
    push_exp(32'h80000000, 1);
    push_exp(32'h00000000, 15);
    compare_run("empty");

    // 55 bytes: pad word lands at index 13, one block.
    clear_run();
    push_msg(8'h41, 55);
    send_msg(1'b1);
    wait_last("b55");
    push_exp(32'h41414141, 13);
    push_exp(32'h41414180, 1);
    push_exp(32'h00000000, 1);
    push_exp(32'h000001B8, 1);
    compare_run("b55");

    // 56 bytes: pad word at index 14 forces a second block.
    clear_run();
    push_msg(8'h41, 56);
    send_msg(1'b1);
    wait_last("b56");
    push_exp(32'h41414141, 14);
    push_exp(32'h80000000, 1);
    push_exp(32'h00000000, 16);
    push_exp(32'h000001C0, 1);
    compare_run("b56");

    // Empty beat without LAST in the middle of "abc" is ignored.
    clear_run();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    wait_last("illegal_empty");
    expect_abc();
    compare_run("illegal_empty");

    // Backpressure on word 0 of "abc".
    clear_run();
    bus.WORD_READY_IN = 1'b0;
    load_abc();
    send_msg(1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_c%0d_valid", c), 64'(bus.WORD_VALID_OUT), 1);
      check($sformatf("bp_c%0d_data", c), 64'(bus.WORD_DATA_OUT), 64'h61626380);
      check($sformatf("bp_c%0d_idx", c), 64'(bus.WORD_IDX_OUT), 0);
      check($sformatf("bp_c%0d_din_ready", c), 64'(bus.DIN_READY_OUT), 0);
      @(posedge clk);
      #1;
    end
    bus.WORD_READY_IN = 1'b1;
    wait_last("bp");
    expect_abc();
    compare_run("bp");

    // Reset after 10 of 20 bytes, then "abc".
    clear_run();
    push_msg(8'h5A, 10);
    send_msg(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.WORD_VALID_OUT), 0);
    check("mid_rst_data", 64'(bus.WORD_DATA_OUT), 0);
    check("mid_rst_idx", 64'(bus.WORD_IDX_OUT), 0);
    check("mid_rst_last", 64'(bus.MSG_LAST_OUT), 0);
    check("mid_rst_din_ready", 64'(bus.DIN_READY_OUT), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_run();
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_quiet_words", 64'(got_data.size()), 0);
    check("mid_rst_quiet_valid", 64'(bus.WORD_VALID_OUT), 0);
    load_abc();
    send_msg(1'b1);
    wait_last("rst_abc");
    expect_abc();
    compare_run("rst_abc");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
